// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of i_pwm in selected_clk cycles, Wishbone register map.
// Optional glitch filter enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        selected_clk,
    input  logic        i_rst,
    input  logic        i_pwm,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [15:0] i_wb_adr,
    input  logic [15:0] i_wb_data,
    output logic [15:0] o_wb_data,
    output logic        o_wb_ack,
    output logic        o_irq
);

    localparam logic [15:0] ADR_CTRL   = 16'h0000;
    localparam logic [15:0] ADR_STATUS = 16'h0002;
    localparam logic [15:0] ADR_PERIOD = 16'h0004;
    localparam logic [15:0] ADR_HIGH   = 16'h0006;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lvl_q, lvl_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    state_t                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [15:0]            hi_cnt_q, hi_cnt_d;
    logic [15:0]            period_q, period_d;
    logic [15:0]            high_q, high_d;
    logic                   en_q, en_d;
    logic                   irq_en_q, irq_en_d;
    logic                   oneshot_q, oneshot_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;
    logic                   ack_q, ack_d;
    logic [15:0]            wb_data_q, wb_data_d;

    logic        sync_out;
    logic        level;
    logic        wb_req;
    logic        wr_ctrl;
    logic        wr_status;
    logic        en_next;
    logic        irq_en_next;
    logic        oneshot_next;
    logic        capture;
    logic        overflow;
    logic        busy;
    logic [15:0] cnt_inc;
    logic [15:0] rd_mux;
    logic        unused_wdata;

    assign sync_out     = sync_q[SYNC_STAGES-1];
    assign unused_wdata = ^i_wb_data[15:3];

`ifdef PWM_CAPTURE_FILTER_EN
    logic       filt_q, filt_d;
    logic [1:0] run_q, run_d;

    // Level follows the synchronizer only after three consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        run_d  = '0;
        if (sync_out != filt_q) begin
            if (run_q == 2'd2) begin
                filt_d = sync_out;
            end else begin
                run_d = run_q + 2'd1;
            end
        end
    end

    always_ff @(posedge selected_clk or posedge i_rst) begin
        if (i_rst) begin
            filt_q <= 1'b0;
            run_q  <= '0;
        end else begin
            filt_q <= filt_d;
            run_q  <= run_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_out;
`endif

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_pwm};
        lvl_d  = level;
        rise_d = level & ~lvl_q;
        fall_d = ~level & lvl_q;
    end

    always_comb begin
        wb_req       = i_wb_cyc & i_wb_stb & ~ack_q;
        wr_ctrl      = wb_req & i_wb_we & (i_wb_adr == ADR_CTRL);
        wr_status    = wb_req & i_wb_we & (i_wb_adr == ADR_STATUS);
        en_next      = wr_ctrl ? i_wb_data[0] : en_q;
        irq_en_next  = wr_ctrl ? i_wb_data[1] : irq_en_q;
        oneshot_next = wr_ctrl ? i_wb_data[2] : oneshot_q;
        busy         = (state_q != ST_IDLE);
        cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
    end

    // Capture FSM; a same-cycle write of EN=0 is folded in via en_next and beats any capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_cnt_d  = hi_cnt_q;
        period_d  = period_q;
        high_d    = high_q;
        en_d      = en_next;
        irq_en_d  = irq_en_next;
        oneshot_d = oneshot_next;
        capture   = 1'b0;
        overflow  = 1'b0;
        if (!en_next) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (rise_q) begin
                        state_d = ST_HIGH;
                        cnt_d   = 16'd1;
                    end
                end
                ST_HIGH: begin
                    if (fall_q) begin
                        hi_cnt_d = cnt_q;
                        cnt_d    = cnt_inc;
                        state_d  = ST_LOW;
                    end else if (cnt_q == '1) begin
                        overflow = 1'b1;
                        state_d  = ST_IDLE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_LOW: begin
                    if (rise_q) begin
                        capture  = 1'b1;
                        period_d = cnt_q;
                        high_d   = hi_cnt_q;
                        cnt_d    = 16'd1;
                        state_d  = ST_HIGH;
                        if (oneshot_next) begin
                            en_d    = 1'b0;
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end else if (cnt_q == '1) begin
                        overflow = 1'b1;
                        state_d  = ST_IDLE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        // Set events win over a write-1-to-clear on the same edge.
        valid_d = capture  | (valid_q & ~(wr_status & i_wb_data[0]));
        ovf_d   = overflow | (ovf_q   & ~(wr_status & i_wb_data[1]));
    end

    always_comb begin
        case (i_wb_adr)
            ADR_CTRL:   rd_mux = {13'd0, oneshot_q, irq_en_q, en_q};
            ADR_STATUS: rd_mux = {13'd0, busy, ovf_q, valid_q};
            ADR_PERIOD: rd_mux = period_q;
            ADR_HIGH:   rd_mux = high_q;
            default:    rd_mux = '0;
        endcase
        ack_d     = wb_req;
        wb_data_d = (wb_req & ~i_wb_we) ? rd_mux : '0;
    end

    always_ff @(posedge selected_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q    <= '0;
            lvl_q     <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_cnt_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            oneshot_q <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            ack_q     <= 1'b0;
            wb_data_q <= '0;
        end else begin
            sync_q    <= sync_d;
            lvl_q     <= lvl_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            oneshot_q <= oneshot_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            ack_q     <= ack_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign o_wb_data = wb_data_q;
    assign o_wb_ack  = ack_q;
    assign o_irq     = valid_q & irq_en_q;

endmodule
